// File: rtl/multicycle_control.sv
// Multicycle datapath control FSM: sequences fetch/decode/execute/memory/writeback,
// drives every datapath strobe, counts retired instructions and flags illegal opcodes.
module multicycle_control #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IorD,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              illegal_q, illegal_d;
    logic              retire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IorD        = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R:         state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_I_EXEC;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                // Opcode is stable here; anything but lw is treated as a store.
                state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEM_WR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            S_I_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_I_WB;
            end
            S_I_WB: begin
                RegWrite = 1'b1;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

        // Reset must silence every strobe immediately, even though FETCH is active.
        if (reset) begin
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IorD        = 1'b0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = 2'b00;
            ALUOp       = 2'b00;
            PCSource    = 2'b00;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
        end
    end

    assign state      = state_q;
    assign retired    = retired_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_multicycle_control;

    typedef struct packed {
        logic       ir, rw, rd, m2r, mr, mw, iord, srca;
        logic [1:0] srcb, aluop, pcsrc;
        logic       pcw, pcwc;
    } outs_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    logic        clk, reset, mem_ready;
    logic [5:0]  opcode;
    logic        IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite, IorD, ALUSrcA;
    logic [1:0]  ALUSrcB, ALUOp, PCSource;
    logic        PCWrite, PCWriteCond, illegal_op;
    logic [3:0]  state;
    logic [31:0] retired;

    logic        IRWrite4, RegWrite4, RegDst4, MemtoReg4, MemRead4, MemWrite4, IorD4, ALUSrcA4;
    logic [1:0]  ALUSrcB4, ALUOp4, PCSource4;
    logic        PCWrite4, PCWriteCond4, illegal_op4;
    logic [3:0]  state4;
    logic [3:0]  retired4;

    outs_t act;
    assign act = {IRWrite, RegWrite, RegDst, MemtoReg, MemRead, MemWrite, IorD, ALUSrcA,
                  ALUSrcB, ALUOp, PCSource, PCWrite, PCWriteCond};

    multicycle_control #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
        .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    multicycle_control #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .IRWrite(IRWrite4), .RegWrite(RegWrite4), .RegDst(RegDst4), .MemtoReg(MemtoReg4),
        .MemRead(MemRead4), .MemWrite(MemWrite4), .IorD(IorD4), .ALUSrcA(ALUSrcA4),
        .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4), .PCSource(PCSource4), .PCWrite(PCWrite4),
        .PCWriteCond(PCWriteCond4), .state(state4), .illegal_op(illegal_op4), .retired(retired4)
    );

    int checks = 0;
    int failures = 0;
    longint unsigned exp_ret = 0;
    bit exp_ill = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected strobes for a state, written straight from the per-state output lists.
    function automatic outs_t exp_out(input int s, input bit rdy);
        outs_t o;
        o = '0;
        case (s)
            0:  begin o.mr = 1; o.srcb = 2'b01; o.ir = rdy; o.pcw = rdy; end
            1:  begin o.srcb = 2'b11; end
            2:  begin o.srca = 1; o.srcb = 2'b10; end
            3:  begin o.mr = 1; o.iord = 1; end
            4:  begin o.rw = 1; o.m2r = 1; end
            5:  begin o.mw = 1; o.iord = 1; end
            6:  begin o.srca = 1; o.aluop = 2'b10; end
            7:  begin o.rw = 1; o.rd = 1; end
            8:  begin o.srca = 1; o.aluop = 2'b01; o.pcsrc = 2'b01; o.pcwc = 1; end
            9:  begin o.pcsrc = 2'b10; o.pcw = 1; end
            10: begin o.srca = 1; o.srcb = 2'b10; end
            11: begin o.rw = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Runs one instruction from its first FETCH cycle; called and returns at a negedge.
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int  sq[$];
        bit  rq[$];
        bit  legal;
        legal = 1;
        for (int i = 0; i <= fw; i++) begin sq.push_back(0); rq.push_back(i == fw); end
        sq.push_back(1); rq.push_back(1'($urandom));
        case (op)
            OP_R:    begin sq.push_back(6); sq.push_back(7); end
            OP_ADDI: begin sq.push_back(10); sq.push_back(11); end
            OP_BEQ:  sq.push_back(8);
            OP_J:    sq.push_back(9);
            OP_LW: begin
                sq.push_back(2);
                for (int i = 0; i <= mw; i++) sq.push_back(3);
                sq.push_back(4);
            end
            OP_SW: begin
                sq.push_back(2);
                for (int i = 0; i <= mw; i++) sq.push_back(5);
            end
            default: legal = 0;
        endcase
        while (rq.size() < sq.size()) begin
            int s;
            s = sq[rq.size()];
            if (s == 3 || s == 5) begin
                for (int i = 0; i <= mw; i++) rq.push_back(i == mw);
            end else begin
                rq.push_back(1'($urandom));
            end
        end
        opcode = op;
        for (int k = 0; k < sq.size(); k++) begin
            mem_ready = rq[k];
            #1;
            checks++;
            if (state !== 4'(sq[k])) begin
                failures++;
                $display("FAIL state op=%b cyc=%0d actual=%0d required=%0d", op, k, state, sq[k]);
            end
            checks++;
            if (act !== exp_out(sq[k], rq[k])) begin
                failures++;
                $display("FAIL strobes op=%b st=%0d actual=%h required=%h", op, sq[k], act, exp_out(sq[k], rq[k]));
            end
            checks++;
            if (retired !== 32'(exp_ret)) begin
                failures++;
                $display("FAIL retired actual=%0d required=%0d", retired, exp_ret);
            end
            checks++;
            if (retired4 !== 4'(exp_ret % 16)) begin
                failures++;
                $display("FAIL retired4 actual=%0d required=%0d", retired4, exp_ret % 16);
            end
            checks++;
            if (illegal_op !== exp_ill) begin
                failures++;
                $display("FAIL illegal_op actual=%b required=%b", illegal_op, exp_ill);
            end
            @(negedge clk);
        end
        if (legal) exp_ret++;
        else exp_ill = 1;
    endtask

    task automatic test_reset();
        reset = 1; mem_ready = 1; opcode = OP_R;
        #1;
        checks++;
        if ({act, state, retired, illegal_op} !== '0) begin
            failures++;
            $display("FAIL reset_outputs actual=%h required=0", {act, state, retired, illegal_op});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({act, state} !== '0) begin
            failures++;
            $display("FAIL reset_held actual=%h required=0", {act, state});
        end
        @(negedge clk);
        reset = 0;
        exp_ret = 0; exp_ill = 0;
    endtask

    task automatic test_rtype();       run_instr(OP_R, 0, 0); endtask
    task automatic test_lw();          run_instr(OP_LW, 0, 2); endtask
    task automatic test_sw_beq();      run_instr(OP_SW, 0, 0); run_instr(OP_BEQ, 0, 0); endtask
    task automatic test_illegal_j();   run_instr(6'b111111, 0, 0); run_instr(OP_J, 1, 0); endtask

    task automatic test_reset_mid_write();
        opcode = OP_SW;
        mem_ready = 1; @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 0;
        #1;
        checks++;
        if (state !== 4'd5 || MemWrite !== 1'b1) begin
            failures++;
            $display("FAIL mid_write_entry actual_state=%0d mw=%b required_state=5 mw=1", state, MemWrite);
        end
        #1 reset = 1;
        #1;
        checks++;
        if ({act, state, retired, retired4, illegal_op} !== '0) begin
            failures++;
            $display("FAIL async_reset actual=%h required=0", {act, state, retired, retired4, illegal_op});
        end
        @(negedge clk);
        reset = 0;
        exp_ret = 0; exp_ill = 0;
        // A j after release checks FETCH resumes with no stray MemWrite and counts from 0.
        run_instr(OP_J, 2, 0);
    endtask

    task automatic test_wrap();
        logic [3:0] start4;
        start4 = 4'(exp_ret % 16);
        for (int i = 0; i < 16; i++) run_instr(OP_J, 0, 0);
        #1;
        checks++;
        if (retired4 !== start4) begin
            failures++;
            $display("FAIL wrap4 actual=%0d required=%0d", retired4, start4);
        end
        checks++;
        if (retired !== 32'(exp_ret)) begin
            failures++;
            $display("FAIL wrap32 actual=%0d required=%0d", retired, exp_ret);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [5:0] ops [6];
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            int pick;
            pick = int'($urandom_range(0, 6));
            if (pick == 6) begin
                do op = 6'($urandom); while (op == OP_R || op == OP_LW || op == OP_SW ||
                                               op == OP_BEQ || op == OP_J || op == OP_ADDI);
            end else begin
                op = ops[pick];
            end
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw();
        test_sw_beq();
        test_illegal_j();
        test_reset_mid_write();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
